// File: rtl/sum_accumulator.sv
// sum_accumulator: collects BLOCK_LEN unsigned adder results over a valid/ready
// handshake, then presents the wider block total with a sticky overflow flag.
// Optional build macro SUM_ACC_SATURATE_EN: clamp the total to all-ones on
// carry-out instead of wrapping modulo 2^ACC_W.
module sum_accumulator #(
  parameter  int DATA_W    = 8,
  parameter  int ACC_W     = 16,
  parameter  int BLOCK_LEN = 4,
  localparam int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              sum_valid,
  output logic              sum_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf,
  output logic [CNT_W-1:0]  sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W:0]    sum_wide;

  // One extra bit captures the carry out of the accumulator.
  assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, sum_in};

  // State register and datapath flops; reset discards any partial/pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and accumulate logic; outputs decode from registered state only.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_ACCUM;
      S_ACCUM: begin
        if (sum_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | sum_wide[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
          // Once clamped, the total stays pinned for the rest of the block.
          acc_d = (sum_wide[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
          acc_d = sum_wide[ACC_W-1:0];
`endif
          if (cnt_q == CNT_W'(BLOCK_LEN - 1)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (acc_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum_ready  = (state_q == S_ACCUM);
  assign acc_valid  = (state_q == S_HOLD);
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a default instance (ACC_W=16) and a narrow
// instance (ACC_W=9) share stimulus; block totals are checked against a
// reference computed from the plain arithmetic sum of the accepted samples.
module tb_sum_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sum_in = '0;
  logic        sum_valid = 1'b0;
  logic        acc_ready = 1'b0;

  logic        sum_ready, acc_valid, acc_ovf;
  logic [15:0] acc_out;
  logic [2:0]  sample_cnt;
  logic        rdy9, vld9, ovf9;
  logic [8:0]  acc9;
  logic [2:0]  cnt9;

  int n_cmp = 0;
  int n_bad = 0;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_ovf(acc_ovf), .sample_cnt(sample_cnt)
  );

  sum_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(rdy9), .acc_out(acc9), .acc_valid(vld9),
    .acc_ready(acc_ready), .acc_ovf(ovf9), .sample_cnt(cnt9)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true sum of the block, then reduced to w bits.
  function automatic void model(input int vals[$], input int w,
                                output int acc, output bit ovf);
    int total = 0;
    int lim   = 1 << w;
    foreach (vals[i]) total += vals[i];
    ovf = (total >= lim);
`ifdef SUM_ACC_SATURATE_EN
    acc = ovf ? lim - 1 : total;
`else
    acc = total % lim;
`endif
  endfunction

  // Offer samples, idling `gap` cycles between them; returns after the last
  // sample has been accepted. A stalled handshake counts as a failure.
  task automatic feed(input int vals[$], input int gap);
    foreach (vals[i]) begin
      bit taken = 1'b0;
      sum_valid = 1'b1;
      sum_in    = vals[i][7:0];
      for (int t = 0; t < 50 && !taken; t++) begin
        taken = sum_ready;
        tick();
      end
      sum_valid = 1'b0;
      if (!taken) begin
        n_cmp++; n_bad++;
        $display("FAIL feed_timeout: sample %0d not accepted within 50 cycles", i);
      end
      if (i != vals.size() - 1) repeat (gap) tick();
    end
  endtask

  // Compares both instances' held block against the reference model.
  task automatic check_block(input string name, input int vals[$]);
    int e16, e9; bit o16, o9;
    model(vals, 16, e16, o16);
    model(vals, 9, e9, o9);
    n_cmp++;
    if (acc_valid !== 1'b1 || vld9 !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_valid: got %b/%b want 1/1", name, acc_valid, vld9);
    end
    n_cmp++;
    if (acc_out !== 16'(e16) || acc_ovf !== o16) begin
      n_bad++;
      $display("FAIL %s_acc16: got %0d ovf %b want %0d ovf %b", name, acc_out, acc_ovf, e16, o16);
    end
    n_cmp++;
    if (acc9 !== 9'(e9) || ovf9 !== o9) begin
      n_bad++;
      $display("FAIL %s_acc9: got %0d ovf %b want %0d ovf %b", name, acc9, ovf9, e9, o9);
    end
    n_cmp++;
    if (sample_cnt !== 3'd4 || sum_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_hold: cnt %0d ready %b want 4/0", name, sample_cnt, sum_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; acc_ready = 1'b0; sum_valid = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (acc_out !== '0 || acc_valid !== 1'b0 || sum_ready !== 1'b0 ||
          acc_ovf !== 1'b0 || sample_cnt !== '0) begin
        n_bad++;
        $display("FAIL reset_state: acc %0d vld %b rdy %b ovf %b cnt %0d want all 0",
                 acc_out, acc_valid, sum_ready, acc_ovf, sample_cnt);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (sum_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: sum_ready %b want 0", sum_ready);
    end
    tick();
    n_cmp++;
    if (sum_ready !== 1'b1 || rdy9 !== 1'b1) begin
      n_bad++; $display("FAIL reset_accum: sum_ready %b/%b want 1", sum_ready, rdy9);
    end
  endtask

  task automatic test_basic();
    int v[$] = '{10, 20, 30, 40};
    acc_ready = 1'b1;
    feed(v, 0);
    check_block("basic", v);
    n_cmp++;
    if (acc_out !== 16'd100) begin
      n_bad++; $display("FAIL basic_100: got %0d want 100", acc_out);
    end
    tick();
    n_cmp++;
    if (acc_valid !== 1'b0 || sample_cnt !== '0 || acc_out !== '0 || sum_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_clear: vld %b cnt %0d acc %0d rdy %b want 0/0/0/1",
               acc_valid, sample_cnt, acc_out, sum_ready);
    end
  endtask

  task automatic test_backpressure();
    int v[$] = '{10, 20, 30, 40};
    int w[$] = '{1, 2, 3, 4};
    acc_ready = 1'b0;
    feed(v, 0);
    check_block("bp", v);
    sum_valid = 1'b1; sum_in = 8'd99;
    repeat (5) begin
      tick();
      n_cmp++;
      if (acc_out !== 16'd100 || sum_ready !== 1'b0 || acc_valid !== 1'b1 || sample_cnt !== 3'd4) begin
        n_bad++;
        $display("FAIL bp_held: acc %0d rdy %b vld %b cnt %0d want 100/0/1/4",
                 acc_out, sum_ready, acc_valid, sample_cnt);
      end
    end
    sum_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    n_cmp++;
    if (acc_out !== '0 || sample_cnt !== '0 || sum_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: acc %0d cnt %0d rdy %b want 0/0/1", acc_out, sample_cnt, sum_ready);
    end
    feed(w, 0);
    check_block("bp_next", w);
    tick();
  endtask

  task automatic test_gaps();
    int v[$] = '{255, 255, 255, 255};
    acc_ready = 1'b1;
    feed(v, 2);
    check_block("gaps", v);
    n_cmp++;
    if (acc_out !== 16'd1020 || acc_ovf !== 1'b0) begin
      n_bad++; $display("FAIL gaps_1020: got %0d ovf %b want 1020 ovf 0", acc_out, acc_ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    int v[$] = '{200, 200, 200, 200};
`ifdef SUM_ACC_SATURATE_EN
    int want9 = 511;
`else
    int want9 = 288;
`endif
    acc_ready = 1'b1;
    feed(v, 0);
    check_block("ovf", v);
    n_cmp++;
    if (acc9 !== 9'(want9) || ovf9 !== 1'b1) begin
      n_bad++; $display("FAIL ovf_narrow: got %0d ovf %b want %0d ovf 1", acc9, ovf9, want9);
    end
    tick();
    n_cmp++;
    if (ovf9 !== 1'b0 || acc9 !== '0) begin
      n_bad++; $display("FAIL ovf_clear: acc %0d ovf %b want 0/0", acc9, ovf9);
    end
  endtask

  task automatic test_reset_mid_block();
    int p[$] = '{5, 6};
    int v[$] = '{1, 2, 3, 4};
    bit up = 1'b0;
    acc_ready = 1'b1;
    feed(p, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (acc_out !== '0 || sample_cnt !== '0 || sum_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state: acc %0d cnt %0d rdy %b want 0/0/0", acc_out, sample_cnt, sum_ready);
    end
    for (int t = 0; t < 10 && !up; t++) begin
      tick();
      up = sum_ready;
    end
    n_cmp++;
    if (!up) begin
      n_bad++; $display("FAIL midrst_ready: sum_ready %b want 1", sum_ready);
    end
    feed(v, 0);
    check_block("midrst", v);
    n_cmp++;
    if (acc_out !== 16'd10) begin
      n_bad++; $display("FAIL midrst_10: got %0d want 10", acc_out);
    end
    tick();
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      int v[$];
      int hold = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) v.push_back($urandom_range(0, 255));
      acc_ready = (hold == 0);
      feed(v, $urandom_range(0, 2));
      check_block("rand", v);
      repeat (hold) tick();
      acc_ready = 1'b1;
      tick();
      n_cmp++;
      if (acc_valid !== 1'b0 || sum_ready !== 1'b1 || acc_out !== '0) begin
        n_bad++;
        $display("FAIL rand_xfer: vld %b rdy %b acc %0d want 0/1/0", acc_valid, sum_ready, acc_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_reset_mid_block();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
